// File: rtl/mc_core_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer for the RV32I datapath; owns the PC and instruction register.
// Latency: FETCH+EXEC+WB for ALU/branch (PC advances on the 4th cycle), plus MEM for load/store (5th cycle), plus wait states.
// Backpressure: req/gnt/rvalid handshakes; stalls in FETCH/FWAIT/MEM for up to MAX_WAIT cycles, then bus-timeout trap.
//
// Ports: clk_i/rst_ni clock and async active-low reset; imem_* instruction fetch handshake;
//   instr_o/pc_o/pc_four_o to the datapath; alu_data_i/br_taken_i/is_load_i/is_store_i/rd_wren_i
//   from ctrl_unit/alu; rd_wren_o gated register write; dmem_* data handshake to the lsu;
//   retire_o/trap_o/trap_cause_o status; mcycle_o/minstret_o performance counters.
// Build option MC_PERF_CNT_EN: when defined, mcycle_o/minstret_o are real 64-bit counters; otherwise tied to 0.
module mc_core_sequencer #(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       IMEM_AW  = 14,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  parameter int unsigned       MAX_WAIT = 15
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               imem_req_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [31:0]        imem_rdata_i,
  output logic [31:0]        instr_o,
  output logic [XLEN-1:0]    pc_o,
  output logic [XLEN-1:0]    pc_four_o,
  input  logic [XLEN-1:0]    alu_data_i,
  input  logic               br_taken_i,
  input  logic               is_load_i,
  input  logic               is_store_i,
  input  logic               rd_wren_i,
  output logic               rd_wren_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  input  logic               dmem_rvalid_i,
  output logic               retire_o,
  output logic               trap_o,
  output logic [1:0]         trap_cause_o,
  output logic [63:0]        mcycle_o,
  output logic [63:0]        minstret_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_FWAIT, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  localparam logic [31:0]     NOP_INSTR   = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP     = XLEN'(4);
  localparam logic [XLEN-1:0] TGT_MASK    = ~XLEN'(1);
  localparam logic [7:0]      WAIT_LAST   = 8'(MAX_WAIT - 1);
  localparam logic [1:0]      CAUSE_ALIGN = 2'b01;
  localparam logic [1:0]      CAUSE_BUS   = 2'b10;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [1:0]      cause_q, cause_d;
  logic [7:0]      wait_q, wait_d;
  logic [XLEN-1:0] pc_next;
  logic            wait_expired;

  assign pc_four_o    = pc_q + PC_STEP;
  // JALR-style target: LSB forced to zero, bit 1 left to the misalignment check.
  assign pc_next      = br_taken_i ? (alu_data_i & TGT_MASK) : pc_four_o;
  // The counter holds cycles already spent in the state, so this is the MAX_WAIT-th cycle.
  assign wait_expired = (wait_q == WAIT_LAST);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    cause_d    = cause_q;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rd_wren_o  = 1'b0;
    retire_o   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        // Gated by reset so requests drop the instant reset asserts.
        imem_req_o = rst_ni;
        if (imem_gnt_i) begin
          if (imem_rvalid_i) begin
            instr_d = imem_rdata_i;
            state_d = S_EXEC;
          end else begin
            state_d = S_FWAIT;
          end
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_FWAIT: begin
        if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          state_d = S_EXEC;
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_EXEC: begin
        state_d = (is_load_i || is_store_i) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req_o = rst_ni;
        dmem_we_o  = rst_ni & is_store_i;
        if (dmem_rvalid_i) begin
          state_d = S_WB;
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_WB: begin
        if (pc_next[1:0] != 2'b00) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ALIGN;
        end else begin
          rd_wren_o = rd_wren_i & ~is_store_i;
          retire_o  = 1'b1;
          pc_d      = pc_next;
          state_d   = S_FETCH;
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (state_q == S_FETCH || state_q == S_FWAIT || state_q == S_MEM) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      cause_q <= 2'b00;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
    end
  end

  assign imem_addr_o  = pc_q[IMEM_AW-1:0];
  assign pc_o         = pc_q;
  assign instr_o      = instr_q;
  assign trap_o       = (state_q == S_TRAP);
  assign trap_cause_o = cause_q;

`ifdef MC_PERF_CNT_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  assign mcycle_d   = (state_q != S_TRAP) ? mcycle_q + 64'd1 : mcycle_q;
  assign minstret_d = retire_o ? minstret_q + 64'd1 : minstret_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign mcycle_o   = mcycle_q;
  assign minstret_o = minstret_q;
`else
  assign mcycle_o   = 64'd0;
  assign minstret_o = 64'd0;
`endif

endmodule

// File: tb/tb_mc_core_sequencer.sv
module tb_mc_core_sequencer;
  localparam int XLEN    = 32;
  localparam int IMEM_AW = 14;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               imem_req_o;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic               imem_gnt_i = 1'b0;
  logic               imem_rvalid_i = 1'b0;
  logic [31:0]        imem_rdata_i = 32'h0;
  logic [31:0]        instr_o;
  logic [XLEN-1:0]    pc_o;
  logic [XLEN-1:0]    pc_four_o;
  logic [XLEN-1:0]    alu_data_i = '0;
  logic               br_taken_i = 1'b0;
  logic               is_load_i = 1'b0;
  logic               is_store_i = 1'b0;
  logic               rd_wren_i = 1'b0;
  logic               rd_wren_o;
  logic               dmem_req_o;
  logic               dmem_we_o;
  logic               dmem_rvalid_i = 1'b0;
  logic               retire_o;
  logic               trap_o;
  logic [1:0]         trap_cause_o;
  logic [63:0]        mcycle_o;
  logic [63:0]        minstret_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mc_core_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_four_o(pc_four_o),
    .alu_data_i(alu_data_i), .br_taken_i(br_taken_i), .is_load_i(is_load_i),
    .is_store_i(is_store_i), .rd_wren_i(rd_wren_i), .rd_wren_o(rd_wren_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_rvalid_i(dmem_rvalid_i),
    .retire_o(retire_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o),
    .mcycle_o(mcycle_o), .minstret_o(minstret_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    alu_data_i = '0; br_taken_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
    rd_wren_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", pc_o, 32'h0); end
    checks++; if (instr_o !== 32'h0000_0013) begin errors++; $display("FAIL rst_instr got %h exp %h", instr_o, 32'h13); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_imem_req got %b exp 0", imem_req_o); end
    checks++; if ({rd_wren_o, retire_o, trap_o, dmem_req_o} !== 4'b0) begin errors++; $display("FAIL rst_ctl got %b exp 0000", {rd_wren_o, retire_o, trap_o, dmem_req_o}); end
    checks++; if (trap_cause_o !== 2'b00) begin errors++; $display("FAIL rst_cause got %b exp 00", trap_cause_o); end
    checks++; if ({mcycle_o, minstret_o} !== 128'h0) begin errors++; $display("FAIL rst_cnt got %h/%h exp 0", mcycle_o, minstret_o); end
    rst_ni = 1'b1;
    cyc = 0;
    tick();
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL rel_imem_req got %b exp 1", imem_req_o); end
    checks++; if (pc_o !== 32'h0 || imem_addr_o !== 14'h0) begin errors++; $display("FAIL rel_pc got %h/%h exp 0", pc_o, imem_addr_o); end
    checks++; if (rd_wren_o !== 1'b0) begin errors++; $display("FAIL rel_wren got %b exp 0", rd_wren_o); end
  endtask

  // addi x1,x0,1 at 0x0 with zero-wait fetch; cycle 1 is the FETCH cycle.
  task automatic test_addi();
    logic e;
    for (int c = 1; c <= 4; c++) begin
      rd_wren_i = 1'b1;
      imem_gnt_i = (c == 1); imem_rvalid_i = (c == 1);
      imem_rdata_i = 32'h0010_0093;
      #1;
      e = (c == 3);
      checks++; if (rd_wren_o !== e) begin errors++; $display("FAIL addi_wren c=%0d got %b exp %b", c, rd_wren_o, e); end
      checks++; if (retire_o !== e) begin errors++; $display("FAIL addi_retire c=%0d got %b exp %b", c, retire_o, e); end
      if (c == 2) begin
        checks++; if (instr_o !== 32'h0010_0093) begin errors++; $display("FAIL addi_instr got %h exp %h", instr_o, 32'h0010_0093); end
      end
      if (c == 3) begin
        checks++; if (pc_four_o !== 32'h4) begin errors++; $display("FAIL addi_pc4 got %h exp 4", pc_four_o); end
      end
      if (c == 4) begin
        checks++; if (pc_o !== 32'h4 || imem_addr_o !== 14'h4) begin errors++; $display("FAIL addi_pc got %h/%h exp 4", pc_o, imem_addr_o); end
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL addi_refetch got %b exp 1", imem_req_o); end
      end
      if (c < 4) tick();
    end
  endtask

  // ALU op at 0x4, grant one cycle before data (FWAIT path), no register write requested.
  task automatic test_fwait();
    logic e;
    for (int c = 1; c <= 5; c++) begin
      rd_wren_i = 1'b0;
      imem_gnt_i = (c == 1); imem_rvalid_i = (c == 2);
      imem_rdata_i = 32'h0020_8133;
      #1;
      e = (c == 1) || (c == 5);
      checks++; if (imem_req_o !== e) begin errors++; $display("FAIL fwait_req c=%0d got %b exp %b", c, imem_req_o, e); end
      checks++; if (retire_o !== (c == 4) || rd_wren_o !== 1'b0) begin errors++; $display("FAIL fwait_wb c=%0d got %b%b exp %b0", c, retire_o, rd_wren_o, c == 4); end
      if (c == 3) begin
        checks++; if (instr_o !== 32'h0020_8133) begin errors++; $display("FAIL fwait_instr got %h exp %h", instr_o, 32'h0020_8133); end
      end
      if (c == 5) begin
        checks++; if (pc_o !== 32'h8) begin errors++; $display("FAIL fwait_pc got %h exp 8", pc_o); end
      end
      if (c < 5) tick();
    end
  endtask

  task automatic test_branch();
    for (int c = 1; c <= 4; c++) begin
      imem_gnt_i = (c == 1); imem_rvalid_i = (c == 1);
      br_taken_i = (c <= 3); alu_data_i = 32'h101;
      #1;
      if (c == 3) begin
        checks++; if (retire_o !== 1'b1) begin errors++; $display("FAIL br_retire got %b exp 1", retire_o); end
      end
      if (c == 4) begin
        checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL br_pc got %h exp 100", pc_o); end
        checks++; if (trap_o !== 1'b0) begin errors++; $display("FAIL br_trap got %b exp 0", trap_o); end
      end
      if (c < 4) tick();
    end
    br_taken_i = 1'b0; alu_data_i = '0;
  endtask

  // Load at 0x100; dmem_rvalid arrives 3 cycles after the request starts.
  task automatic test_load();
    logic e;
    for (int c = 1; c <= 8; c++) begin
      imem_gnt_i = (c == 1); imem_rvalid_i = (c == 1);
      is_load_i = (c < 8); rd_wren_i = (c < 8);
      dmem_rvalid_i = (c == 6);
      #1;
      e = (c >= 3) && (c <= 6);
      checks++; if (dmem_req_o !== e || dmem_we_o !== 1'b0) begin errors++; $display("FAIL ld_req c=%0d got %b%b exp %b0", c, dmem_req_o, dmem_we_o, e); end
      checks++; if (rd_wren_o !== (c == 7)) begin errors++; $display("FAIL ld_wren c=%0d got %b exp %b", c, rd_wren_o, c == 7); end
      if (c == 8) begin
        checks++; if (pc_o !== 32'h104) begin errors++; $display("FAIL ld_pc got %h exp 104", pc_o); end
      end
      if (c < 8) tick();
    end
    is_load_i = 1'b0; rd_wren_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  // Branch at 0x104 to 0xFFFF_FFFC, then a sequential op there wraps the PC to 0.
  task automatic test_wrap();
    for (int c = 1; c <= 7; c++) begin
      imem_gnt_i = (c == 1) || (c == 4); imem_rvalid_i = imem_gnt_i;
      br_taken_i = (c <= 3); alu_data_i = 32'hFFFF_FFFC;
      #1;
      if (c == 4) begin
        checks++; if (pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", pc_o); end
        checks++; if (imem_addr_o !== 14'h3FFC) begin errors++; $display("FAIL wrap_addr got %h exp 3ffc", imem_addr_o); end
        checks++; if (pc_four_o !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", pc_four_o); end
      end
      if (c == 7) begin
        checks++; if (pc_o !== 32'h0 || trap_o !== 1'b0) begin errors++; $display("FAIL wrap_next got %h/%b exp 0/0", pc_o, trap_o); end
      end
      if (c < 7) tick();
    end
    br_taken_i = 1'b0; alu_data_i = '0;
  endtask

  // Zero-wait store at 0x0 with rd_wren_i high: no register write.
  task automatic test_store();
    for (int c = 1; c <= 5; c++) begin
      imem_gnt_i = (c == 1); imem_rvalid_i = (c == 1);
      is_store_i = (c < 5); rd_wren_i = (c < 5); dmem_rvalid_i = (c == 3);
      #1;
      checks++; if (dmem_req_o !== (c == 3) || dmem_we_o !== (c == 3)) begin errors++; $display("FAIL st_req c=%0d got %b%b exp %b%b", c, dmem_req_o, dmem_we_o, c == 3, c == 3); end
      checks++; if (retire_o !== (c == 4) || rd_wren_o !== 1'b0) begin errors++; $display("FAIL st_wb c=%0d got %b%b exp %b0", c, retire_o, rd_wren_o, c == 4); end
      if (c == 5) begin
        checks++; if (pc_o !== 32'h4) begin errors++; $display("FAIL st_pc got %h exp 4", pc_o); end
      end
      if (c < 5) tick();
    end
    is_store_i = 1'b0; rd_wren_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  // Jump at 0x4 to 0x106: misaligned, no retire/write, core halts.
  task automatic test_misaligned();
    longint exp_mc;
    exp_mc = 0;
    for (int c = 1; c <= 8; c++) begin
      imem_gnt_i = (c == 1) || (c >= 4); imem_rvalid_i = imem_gnt_i;
      br_taken_i = 1'b1; alu_data_i = 32'h106; rd_wren_i = 1'b1;
      #1;
      if (c == 3) begin
        checks++; if (retire_o !== 1'b0 || rd_wren_o !== 1'b0) begin errors++; $display("FAIL mis_wb got %b%b exp 00", retire_o, rd_wren_o); end
      end
      if (c >= 4) begin
        checks++; if (trap_o !== 1'b1 || trap_cause_o !== 2'b01) begin errors++; $display("FAIL mis_trap c=%0d got %b/%b exp 1/01", c, trap_o, trap_cause_o); end
        checks++; if (imem_req_o !== 1'b0 || pc_o !== 32'h4) begin errors++; $display("FAIL mis_halt c=%0d got %b/%h exp 0/4", c, imem_req_o, pc_o); end
      end
`ifdef MC_PERF_CNT_EN
      if (c == 4) begin
        exp_mc = longint'(cyc);
        checks++; if (minstret_o !== 64'd7) begin errors++; $display("FAIL mis_minstret got %0d exp 7", minstret_o); end
      end
      if (c == 8) begin
        checks++; if (mcycle_o !== 64'(exp_mc)) begin errors++; $display("FAIL mis_mcycle got %0d exp %0d", mcycle_o, exp_mc); end
      end
`else
      if (c == 8) begin
        checks++; if ({mcycle_o, minstret_o} !== 128'h0) begin errors++; $display("FAIL mis_cnt got %h/%h exp 0", mcycle_o, minstret_o); end
      end
`endif
      if (c < 8) tick();
    end
    clear_inputs();
  endtask

  // Reset asserted during MEM must drop dmem_req_o without waiting for a clock edge.
  task automatic test_reset_mid();
    do_reset();
    imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; is_load_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    tick();
    #1;
    checks++; if (dmem_req_o !== 1'b1) begin errors++; $display("FAIL mid_mem_req got %b exp 1", dmem_req_o); end
    rst_ni = 1'b0;
    dmem_rvalid_i = 1'b1;
    #1;
    checks++; if (dmem_req_o !== 1'b0 || imem_req_o !== 1'b0 || rd_wren_o !== 1'b0) begin errors++; $display("FAIL mid_drop got %b%b%b exp 000", dmem_req_o, imem_req_o, rd_wren_o); end
    clear_inputs();
  endtask

  // imem_gnt_i held low: bus-timeout trap after 15 FETCH cycles.
  task automatic test_timeout();
    do_reset();
    for (int c = 1; c <= 15; c++) begin
      #1;
      checks++; if (imem_req_o !== 1'b1 || trap_o !== 1'b0) begin errors++; $display("FAIL to_wait c=%0d got %b/%b exp 1/0", c, imem_req_o, trap_o); end
      tick();
    end
    #1;
    checks++; if (trap_o !== 1'b1 || trap_cause_o !== 2'b10) begin errors++; $display("FAIL to_trap got %b/%b exp 1/10", trap_o, trap_cause_o); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL to_req got %b exp 0", imem_req_o); end
    repeat (5) tick();
`ifdef MC_PERF_CNT_EN
    checks++; if (mcycle_o !== 64'd15 || minstret_o !== 64'd0) begin errors++; $display("FAIL to_cnt got %0d/%0d exp 15/0", mcycle_o, minstret_o); end
`else
    checks++; if (mcycle_o !== 64'd0 || minstret_o !== 64'd0) begin errors++; $display("FAIL to_cnt got %0d/%0d exp 0/0", mcycle_o, minstret_o); end
`endif
    checks++; if (trap_o !== 1'b1 || imem_req_o !== 1'b0) begin errors++; $display("FAIL to_hold got %b/%b exp 1/0", trap_o, imem_req_o); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_fwait();
    test_branch();
    test_load();
    test_wrap();
    test_store();
    test_misaligned();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
